bip_control_unit: RTL and testbench

BIP_CONTROL_UNIT -- requirements
Module: bip_control_unit

---
 rtl/bip_control_unit.sv | 132 +++++++++++++
 tb/tb_bip_control_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bip_control_unit.sv
// bip_control_unit: fetch/decode/execute sequencer for the BIP accumulator CPU.
// Ports: clk, rst_n (async, active low), start, instruction/instrValid from
// program memory; fetchReq/pcAddress to program memory; operand to the sign
// extender; selA/selB/aluOp/wrAcc/wrRam/rdRam datapath controls; busy/halted status.
// Define BIP_INSTR_COUNTER_EN to add the 16-bit instrCount output (EXECUTE cycles retired).
module bip_control_unit #(
  parameter int OPCODE_LENGTH  = 5,
  parameter int OPERAND_LENGTH = 11,
  parameter int PC_LENGTH      = 11
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [15:0]               instruction,
  input  logic                      instrValid,
  output logic                      fetchReq,
  output logic [PC_LENGTH-1:0]      pcAddress,
  output logic [OPERAND_LENGTH-1:0] operand,
  output logic [1:0]                selA,
  output logic                      selB,
  output logic                      wrAcc,
  output logic                      aluOp,
  output logic                      wrRam,
  output logic                      rdRam,
  output logic                      busy,
  output logic                      halted
`ifdef BIP_INSTR_COUNTER_EN
  ,
  output logic [15:0]               instrCount
`endif
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, HALT} state_t;
  localparam logic [OPCODE_LENGTH-1:0] OP_HLT  = OPCODE_LENGTH'(0);
  localparam logic [OPCODE_LENGTH-1:0] OP_STO  = OPCODE_LENGTH'(1);
  localparam logic [OPCODE_LENGTH-1:0] OP_LD   = OPCODE_LENGTH'(2);
  localparam logic [OPCODE_LENGTH-1:0] OP_LDI  = OPCODE_LENGTH'(3);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(4);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADDI = OPCODE_LENGTH'(5);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = OPCODE_LENGTH'(6);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUBI = OPCODE_LENGTH'(7);
  state_t                      state_q, state_d;
  logic [PC_LENGTH-1:0]        pc_q, pc_d;
  logic [OPERAND_LENGTH-1:0]   operand_q, operand_d;
  logic [1:0]                  sel_a_q, sel_a_d;
  logic                        sel_b_q, sel_b_d, alu_op_q, alu_op_d;
  logic                        acc_en_q, acc_en_d, ram_wr_q, ram_wr_d, ram_rd_q, ram_rd_d, hlt_q, hlt_d;
  logic [OPCODE_LENGTH-1:0]    opc;
  logic                        is_alu;
  assign opc    = instruction[15 -: OPCODE_LENGTH];
  assign is_alu = opc >= OP_ADD && opc <= OP_SUBI;
  // Controls are decoded and registered at the fetch handshake so they are
  // stable through DECODE/EXECUTE; strobes are then gated by state only.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    operand_d = operand_q;
    sel_a_d   = sel_a_q;
    sel_b_d   = sel_b_q;
    alu_op_d  = alu_op_q;
    acc_en_d  = acc_en_q;
    ram_wr_d  = ram_wr_q;
    ram_rd_d  = ram_rd_q;
    hlt_d     = hlt_q;
    case (state_q)
      IDLE:    state_d = start ? FETCH : IDLE;
      FETCH:
        if (instrValid) begin
          state_d   = DECODE;
          operand_d = instruction[OPERAND_LENGTH-1:0];
          sel_a_d   = opc == OP_LDI ? 2'd1 : is_alu ? 2'd2 : 2'd0;
          sel_b_d   = opc == OP_ADDI || opc == OP_SUBI;
          alu_op_d  = opc == OP_SUB || opc == OP_SUBI;
          acc_en_d  = opc >= OP_LD && opc <= OP_SUBI;
          ram_wr_d  = opc == OP_STO;
          ram_rd_d  = opc == OP_LD || opc == OP_ADD || opc == OP_SUB;
          hlt_d     = opc == OP_HLT;
        end
      // HLT never reaches EXECUTE, so the PC and the retire counter stay put.
      DECODE:  state_d = hlt_q ? HALT : EXECUTE;
      EXECUTE: begin
        state_d = FETCH;
        pc_d    = pc_q + PC_LENGTH'(1);
      end
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      operand_q <= '0;
      sel_a_q   <= '0;
      sel_b_q   <= 1'b0;
      alu_op_q  <= 1'b0;
      acc_en_q  <= 1'b0;
      ram_wr_q  <= 1'b0;
      ram_rd_q  <= 1'b0;
      hlt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      operand_q <= operand_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      alu_op_q  <= alu_op_d;
      acc_en_q  <= acc_en_d;
      ram_wr_q  <= ram_wr_d;
      ram_rd_q  <= ram_rd_d;
      hlt_q     <= hlt_d;
    end
  end
  assign fetchReq  = state_q == FETCH;
  assign busy      = state_q == FETCH || state_q == DECODE || state_q == EXECUTE;
  assign halted    = state_q == HALT;
  assign rdRam     = state_q == DECODE && ram_rd_q;
  assign wrAcc     = state_q == EXECUTE && acc_en_q;
  assign wrRam     = state_q == EXECUTE && ram_wr_q;
  assign pcAddress = pc_q;
  assign operand   = operand_q;
  assign selA      = sel_a_q;
  assign selB      = sel_b_q;
  assign aluOp     = alu_op_q;
`ifdef BIP_INSTR_COUNTER_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = state_q == EXECUTE ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign instrCount = cnt_q;
`endif
endmodule

// File: tb/tb_bip_control_unit.sv
// tb_bip_control_unit: table-driven scoreboard bench for bip_control_unit.
module tb_bip_control_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] instruction = '0;
  logic        instrValid = 1'b0;
  logic        fetchReq, selB, wrAcc, aluOp, wrRam, rdRam, busy, halted;
  logic [10:0] pcAddress, operand;
  logic [1:0]  selA;
`ifdef BIP_INSTR_COUNTER_EN
  logic [15:0] instr_count;
`endif
  int n_chk = 0, n_pass = 0, n_exec = 0;

  typedef struct {
    logic [15:0] ins;
    int          dly;
    logic [10:0] opnd;
    logic [1:0]  sel_a;
    logic        sel_b, alu, wr_acc, wr_ram, rd_ram;
  } vec_t;
  vec_t vecs[9];
  vec_t exp_q[$];

  bip_control_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instruction(instruction),
    .instrValid(instrValid), .fetchReq(fetchReq), .pcAddress(pcAddress),
    .operand(operand), .selA(selA), .selB(selB), .wrAcc(wrAcc), .aluOp(aluOp),
    .wrRam(wrRam), .rdRam(rdRam), .busy(busy), .halted(halted)
`ifdef BIP_INSTR_COUNTER_EN
    , .instrCount(instr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({fetchReq, busy, halted, wrAcc, wrRam, rdRam, selA, selB, aluOp} == 10'd0,
        {name, "_ctrl"}, int'({fetchReq, busy, halted, wrAcc, wrRam, rdRam, selA, selB, aluOp}), 0);
    chk(pcAddress == 11'd0 && operand == 11'd0, {name, "_pc_opnd"}, int'({pcAddress, operand}), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    instrValid = 1'b0;
    repeat (2) tick();
    chk_reset_vals("reset");
`ifdef BIP_INSTR_COUNTER_EN
    chk(instr_count == 16'd0, "reset_count", instr_count, 0);
`endif
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk(!busy && !fetchReq, "idle_after_reset", int'({busy, fetchReq}), 0);
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (!fetchReq && n < 8) begin
      tick();
      n++;
    end
    chk(fetchReq, "fetch_req", fetchReq, 1);
  endtask

  task automatic do_instr(input vec_t v);
    logic [10:0] pc0;
    vec_t e;
    wait_fetch();
    pc0 = pcAddress;
    instrValid = 1'b0;
    for (int i = 0; i < v.dly; i++) begin
      tick();
      chk(fetchReq && pcAddress == pc0 && !wrAcc && !wrRam && !rdRam, "fetch_stall", pcAddress, pc0);
    end
    instruction = v.ins;
    instrValid = 1'b1;
    exp_q.push_back(v);
    tick();
    instrValid = 1'b0;
    chk(busy && rdRam == v.rd_ram && !wrAcc && !wrRam, "decode_rd", int'({rdRam, wrAcc, wrRam}), int'({v.rd_ram, 2'b00}));
    tick();
    e = exp_q.pop_front();
    n_exec++;
    chk(operand == e.opnd, "operand", operand, e.opnd);
    chk(wrAcc == e.wr_acc && wrRam == e.wr_ram && !rdRam, "exec_strobes",
        int'({wrAcc, wrRam, rdRam}), int'({e.wr_acc, e.wr_ram, 1'b0}));
    if (e.wr_acc) chk(selA == e.sel_a, "sel_a", selA, e.sel_a);
    if (e.sel_a == 2'd2) chk(selB == e.sel_b && aluOp == e.alu, "selb_aluop",
                             int'({selB, aluOp}), int'({e.sel_b, e.alu}));
    chk(pcAddress == pc0, "pc_hold_exec", pcAddress, pc0);
    tick();
    chk(fetchReq && !wrAcc && !wrRam && pcAddress == pc0 + 11'd1, "pc_inc", pcAddress, int'(pc0 + 11'd1));
  endtask

  initial begin
    int n;
    logic [10:0] pc0;
    //          ins       dly opnd      selA  selB  alu   wrAcc wrRam rdRam
    vecs[0] = '{16'h1805, 0, 11'h005, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'h0923, 4, 11'h123, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h1007, 1, 11'h007, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{16'h2009, 2, 11'h009, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{16'h2803, 0, 11'h003, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16'h3007, 0, 11'h007, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'h3801, 1, 11'h001, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{16'h4055, 0, 11'h055, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{16'hFFFF, 0, 11'h7FF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    do_reset();
    start = 1'b1;
    foreach (vecs[i]) do_instr(vecs[i]);

    // HLT: no strobes, PC frozen, start ignored, counter frozen
    wait_fetch();
    pc0 = pcAddress;
    instruction = 16'h0000;
    instrValid = 1'b1;
    tick();
    instrValid = 1'b0;
    chk(busy && !rdRam && !wrAcc && !wrRam, "hlt_decode", int'({rdRam, wrAcc, wrRam}), 0);
    tick();
    chk(halted && !busy && !fetchReq, "halted", int'({halted, busy, fetchReq}), 4);
    chk(pcAddress == 11'd9 && pcAddress == pc0, "hlt_pc", pcAddress, 9);
    repeat (5) tick();
    chk(halted && !busy && !fetchReq && !wrAcc && !wrRam && !rdRam && pcAddress == 11'd9,
        "halt_sticky", int'({halted, busy, fetchReq, wrAcc, wrRam, rdRam}), 32);
`ifdef BIP_INSTR_COUNTER_EN
    chk(instr_count == 16'd9, "count_halt", instr_count, 9);
`endif

    // Run NOPs up to PC 2047, then check wrap to 0
    do_reset();
    n_exec = 0;
    instruction = 16'hF800;
    instrValid = 1'b1;
    start = 1'b1;
    n = 0;
    while (pcAddress != 11'd2047 && n < 7000) begin
      tick();
      n++;
    end
    instrValid = 1'b0;
    chk(pcAddress == 11'd2047, "reach_2047", pcAddress, 2047);
    do_instr('{16'hF800, 0, 11'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk(pcAddress == 11'd0, "pc_wrap", pcAddress, 0);
`ifdef BIP_INSTR_COUNTER_EN
    chk(instr_count == 16'd2048, "count_wrap_run", instr_count, 2048);
`endif

    // Reset asserted mid-EXECUTE of STO
    wait_fetch();
    instruction = 16'h0923;
    instrValid = 1'b1;
    tick();
    instrValid = 1'b0;
    tick();
    chk(wrRam, "sto_wr_before_rst", wrRam, 1);
    #2 rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk(!wrRam, "sto_wr_async_drop", wrRam, 0);
    chk_reset_vals("mid_rst");
    repeat (2) tick();
    chk(!busy && !fetchReq && !wrRam, "held_in_reset", int'({busy, fetchReq, wrRam}), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk(!busy && !fetchReq && !halted, "idle_after_release", int'({busy, fetchReq, halted}), 0);
    start = 1'b1;
    tick();
    chk(fetchReq && busy && pcAddress == 11'd0, "restart_fetch", int'({fetchReq, busy}), 3);
    chk(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
